// File: rtl/fb_pkg.sv
// Shared framebuffer constants, writer FSM states and the pixel-to-address helper.
// Used by the rasterizer-side writer and the scan-out reader.
package fb_pkg;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int FB_ADDR_W = 19;
  localparam int COLOR_W   = 3;
  localparam int X_W       = 10;
  localparam int Y_W       = 9;

  typedef enum logic [1:0] {
    ST_ACCEPT    = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_SWAP_WAIT = 2'd2
  } fb_wr_state_t;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
  } fb_pixel_t;

  // y*640 + x without a multiplier: 640 = 512 + 128.
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
    logic [FB_ADDR_W-1:0] yw;
    yw = FB_ADDR_W'(y);
    return (yw << 9) + (yw << 7) + FB_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational range check and linear framebuffer address for one (x, y) pair.
// Shared between the rasterizer writer and the scan-out reader.
module fb_addr_calc
  import fb_pkg::*;
(
  input  logic [X_W-1:0]       x,
  input  logic [Y_W-1:0]       y,
  output logic                 in_range,
  output logic [FB_ADDR_W-1:0] addr
);

  assign in_range = (x < X_W'(H_RES)) && (y < Y_W'(V_RES));
  assign addr     = fb_addr(x, y);

endmodule

// File: rtl/rast_fb_writer.sv
// Rasterizer pixel receiver: two-stage pipeline into the back bank of a
// double-buffered framebuffer, with drain-then-vblank bank swapping.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_ACCEPT    | taking pixels; a switch request edge moves to ST_DRAIN
//   ST_DRAIN     | input closed; waiting for S1 and S2 to empty
//   ST_SWAP_WAIT | pipeline empty; swap banks on the first vblank cycle
module rast_fb_writer
  import fb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rast_pixel_rdy,
  input  logic [COLOR_W-1:0]   rast_color_input,
  input  logic [X_W-1:0]       rast_width,
  input  logic [Y_W-1:0]       rast_height,
  input  logic                 next_frame_switch,
  output logic                 read_rast_pixel_rdy,
  output logic                 fb_wr_en,
  output logic [FB_ADDR_W-1:0] fb_wr_addr,
  output logic [COLOR_W-1:0]   fb_wr_data,
  output logic                 fb_wr_bank,
  input  logic                 fb_wr_rdy,
  input  logic                 display_vblank,
  output logic                 display_bank,
  output logic                 swap_done,
  output logic [15:0]          dropped_cnt
);

  fb_wr_state_t         state;
  logic                 run_q;
  logic                 nfs_q;
  logic                 switch_edge;
  logic                 s1_valid;
  fb_pixel_t            s1_pix;
  logic                 s1_in_range;
  logic [FB_ADDR_W-1:0] s1_addr;
  logic                 s2_valid;
  logic                 s2_free;
  logic                 s1_adv;
  logic                 pix_accept;

  fb_addr_calc u_addr_calc (
    .x        (s1_pix.x),
    .y        (s1_pix.y),
    .in_range (s1_in_range),
    .addr     (s1_addr)
  );

  assign switch_edge = next_frame_switch && !nfs_q;
  assign s2_free     = !s2_valid || fb_wr_rdy;
  // Out-of-range pixels are consumed in S1 even while S2 is stalled.
  assign s1_adv      = s1_valid && (s2_free || !s1_in_range);

  // run_q keeps ready low through reset and for the release cycle itself.
  assign read_rast_pixel_rdy = run_q && (state == ST_ACCEPT) &&
                               !(s1_valid && s2_valid && !fb_wr_rdy);
  assign pix_accept = rast_pixel_rdy && read_rast_pixel_rdy;

  assign fb_wr_en   = s2_valid;
  assign fb_wr_bank = ~display_bank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
    end else if (pix_accept) begin
      s1_valid <= 1'b1;
      s1_pix   <= '{x: rast_width, y: rast_height, color: rast_color_input};
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Address and data only change when S2 can take a new entry, so they hold under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      fb_wr_addr <= '0;
      fb_wr_data <= '0;
    end else if (s2_free) begin
      s2_valid <= s1_valid && s1_in_range;
      if (s1_valid && s1_in_range) begin
        fb_wr_addr <= s1_addr;
        fb_wr_data <= s1_pix.color;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dropped_cnt <= '0;
    end else if (s1_valid && !s1_in_range && (dropped_cnt != 16'hFFFF)) begin
      dropped_cnt <= dropped_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_ACCEPT;
      nfs_q        <= 1'b0;
      run_q        <= 1'b0;
      display_bank <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      nfs_q     <= next_frame_switch;
      run_q     <= 1'b1;
      swap_done <= 1'b0;
      case (state)
        ST_ACCEPT: begin
          if (switch_edge) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!s1_valid && !s2_valid) state <= ST_SWAP_WAIT;
        end
        ST_SWAP_WAIT: begin
          if (display_vblank) begin
            display_bank <= ~display_bank;
            swap_done    <= 1'b1;
            state        <= ST_ACCEPT;
          end
        end
        default: state <= ST_ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_rast_fb_writer.sv
// Scoreboard bench for rast_fb_writer: randomized pixels checked against a
// coordinate-level model of where each pixel must land.
module tb_rast_fb_writer;
  import fb_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 rast_pixel_rdy;
  logic [COLOR_W-1:0]   rast_color_input;
  logic [X_W-1:0]       rast_width;
  logic [Y_W-1:0]       rast_height;
  logic                 next_frame_switch;
  logic                 read_rast_pixel_rdy;
  logic                 fb_wr_en;
  logic [FB_ADDR_W-1:0] fb_wr_addr;
  logic [COLOR_W-1:0]   fb_wr_data;
  logic                 fb_wr_bank;
  logic                 fb_wr_rdy;
  logic                 display_vblank;
  logic                 display_bank;
  logic                 swap_done;
  logic [15:0]          dropped_cnt;

  rast_fb_writer dut (
    .clk                 (clk),
    .rst                 (rst),
    .rast_pixel_rdy      (rast_pixel_rdy),
    .rast_color_input    (rast_color_input),
    .rast_width          (rast_width),
    .rast_height         (rast_height),
    .next_frame_switch   (next_frame_switch),
    .read_rast_pixel_rdy (read_rast_pixel_rdy),
    .fb_wr_en            (fb_wr_en),
    .fb_wr_addr          (fb_wr_addr),
    .fb_wr_data          (fb_wr_data),
    .fb_wr_bank          (fb_wr_bank),
    .fb_wr_rdy           (fb_wr_rdy),
    .display_vblank      (display_vblank),
    .display_bank        (display_bank),
    .swap_done           (swap_done),
    .dropped_cnt         (dropped_cnt)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int addr;
    int color;
    int bank;
    int acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_drop = 0;
  int   model_back = 1;
  int   swaps = 0;
  int   writes = 0;
  bit   lat_check = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard on every completed write.
  initial begin : monitor
    bit                   stall_prev;
    logic [FB_ADDR_W-1:0] held_addr;
    logic [COLOR_W-1:0]   held_data;
    exp_t                 e;
    stall_prev = 0;
    held_addr  = '0;
    held_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        model_back = 1;
        stall_prev = 0;
      end else begin
        if (swap_done) begin
          model_back = 1 - model_back;
          swaps++;
        end
        check("fb_wr_bank", fb_wr_bank, model_back);
        check("display_bank", display_bank, 1 - model_back);
        if (fb_wr_en && stall_prev) begin
          check("stall_addr_hold", fb_wr_addr, held_addr);
          check("stall_data_hold", fb_wr_data, held_data);
        end
        if (fb_wr_en && fb_wr_rdy) begin
          check("write_expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("wr_addr", fb_wr_addr, e.addr);
            check("wr_data", fb_wr_data, e.color);
            check("wr_bank", fb_wr_bank, e.bank);
            if (lat_check) check("latency", cyc - e.acc_cyc, 2);
          end
          writes++;
        end
        stall_prev = fb_wr_en && !fb_wr_rdy;
        held_addr  = fb_wr_addr;
        held_data  = fb_wr_data;
      end
    end
  end

  // Reference: a pixel in the 640x480 window lands at y*640+x in the current back bank.
  task automatic model_push(input int x, input int y, input int c);
    if (x < 640 && y < 480) sb.push_back('{y * 640 + x, c, model_back, cyc});
    else if (exp_drop < 65535) exp_drop++;
  endtask

  task automatic send_pixel(input int x, input int y, input int c);
    int n;
    rast_pixel_rdy   = 1'b1;
    rast_width       = x[X_W-1:0];
    rast_height      = y[Y_W-1:0];
    rast_color_input = c[COLOR_W-1:0];
    n = 0;
    forever begin
      @(negedge clk);
      if (read_rast_pixel_rdy) begin
        model_push(x, y, c);
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 200) begin
        check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    rast_pixel_rdy = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_empty();
    int n;
    rast_pixel_rdy = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_scoreboard", sb.size(), 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_pixel(input bit allow_bad);
    int x, y;
    if (allow_bad && $urandom_range(0, 3) == 0) begin
      if ($urandom_range(0, 1) == 1) begin
        x = $urandom_range(640, 1023); y = $urandom_range(0, 511);
      end else begin
        x = $urandom_range(0, 1023);   y = $urandom_range(480, 511);
      end
    end else begin
      x = $urandom_range(0, 639); y = $urandom_range(0, 479);
    end
    send_pixel(x, y, $urandom_range(0, 7));
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  w0, s0, first_k;
    bit  seen, done;
    rst = 1'b1;
    rast_pixel_rdy = 1'b0; rast_color_input = '0; rast_width = '0; rast_height = '0;
    next_frame_switch = 1'b0; fb_wr_rdy = 1'b1; display_vblank = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", read_rast_pixel_rdy, 0);
    check("rst_wr_en", fb_wr_en, 0);
    check("rst_wr_addr", fb_wr_addr, 0);
    check("rst_wr_data", fb_wr_data, 0);
    check("rst_display_bank", display_bank, 0);
    check("rst_fb_wr_bank", fb_wr_bank, 1);
    check("rst_swap_done", swap_done, 0);
    check("rst_dropped", dropped_cnt, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_release", read_rast_pixel_rdy, 1);

    // Corner pixels back to back, latency checked on each write.
    lat_check = 1;
    w0 = writes;
    send_pixel(0, 0, 1);
    send_pixel(639, 0, 5);
    send_pixel(0, 1, 2);
    send_pixel(639, 479, 3);
    wait_empty();
    lat_check = 0;
    check("corner_writes", writes - w0, 4);

    send_pixel(640, 0, 1);
    send_pixel(0, 480, 2);
    idle(3);
    check("dropped_two", dropped_cnt, 2);

    // Five-cycle memory stall in the middle of a burst.
    w0 = writes; seen = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) rand_pixel(0);
      end
      begin
        repeat (3) begin @(posedge clk); #1; end
        fb_wr_rdy = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (!read_rast_pixel_rdy) seen = 1;
          @(posedge clk); #1;
        end
        fb_wr_rdy = 1'b1;
      end
    join
    wait_empty();
    check("stall_ready_dropped", seen, 1);
    check("stall_writes", writes - w0, 10);

    // Random traffic with random memory back-pressure.
    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) rand_pixel(1);
        done = 1;
      end
      begin
        while (!done) begin
          fb_wr_rdy = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        fb_wr_rdy = 1'b1;
      end
    join
    wait_empty();
    check("random_dropped", dropped_cnt, exp_drop);

    // Switch edge together with the second of two pixels, vblank held off.
    s0 = swaps;
    send_pixel(10, 20, 6);
    next_frame_switch = 1'b1;
    send_pixel(11, 20, 7);
    rast_pixel_rdy = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (read_rast_pixel_rdy) seen = 1;
      @(posedge clk); #1;
    end
    check("drain_ready_low", seen, 0);
    check("drain_writes_done", sb.size(), 0);
    display_vblank = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (swap_done) seen = 1;
    end
    check("swap_pulse_seen", seen, 1);
    check("swap_display_bank", display_bank, 1);
    check("swap_fb_wr_bank", fb_wr_bank, 0);
    @(posedge clk); #1;
    check("swap_pulse_single", swap_done, 0);
    display_vblank = 1'b0;
    idle(2);
    check("swap_count_a", swaps - s0, 1);

    // Minimum request-to-swap delay, then switch held high for 1000 cycles.
    next_frame_switch = 1'b0;
    display_vblank = 1'b1;
    idle(3);
    s0 = swaps;
    next_frame_switch = 1'b1;
    first_k = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk); #1;
      if (swap_done && first_k == 0) first_k = k;
    end
    check("swap_min_delay", first_k, 3);
    idle(2);
    check("held_high_one_swap", swaps - s0, 1);
    check("held_display_bank", display_bank, 0);

    // A second edge while waiting for vblank is ignored.
    display_vblank = 1'b0;
    next_frame_switch = 1'b0;
    idle(2);
    s0 = swaps;
    next_frame_switch = 1'b1; idle(4);
    next_frame_switch = 1'b0; idle(2);
    next_frame_switch = 1'b1; idle(3);
    display_vblank = 1'b1;    idle(5);
    display_vblank = 1'b0;    idle(30);
    check("second_edge_ignored", swaps - s0, 1);
    check("second_display_bank", display_bank, 1);
    next_frame_switch = 1'b0;
    idle(2);
    send_pixel(100, 200, 3);
    wait_empty();

    // Saturation of the drop counter.
    for (int i = 0; i < 70000; i++) send_pixel(700, 10, 1);
    idle(3);
    check("dropped_saturated", dropped_cnt, 16'hFFFF);
    check("dropped_model", dropped_cnt, exp_drop);

    // Reset in the middle of a stalled drain.
    fb_wr_rdy = 1'b0;
    send_pixel(1, 1, 1);
    send_pixel(2, 2, 2);
    next_frame_switch = 1'b1;
    idle(3);
    check("drain_stuck_ready", read_rast_pixel_rdy, 0);
    check("drain_stuck_wr_en", fb_wr_en, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_wr_en", fb_wr_en, 0);
    check("arst_wr_addr", fb_wr_addr, 0);
    check("arst_wr_data", fb_wr_data, 0);
    check("arst_display_bank", display_bank, 0);
    check("arst_fb_wr_bank", fb_wr_bank, 1);
    check("arst_swap_done", swap_done, 0);
    check("arst_dropped", dropped_cnt, 0);
    check("arst_ready", read_rast_pixel_rdy, 0);
    exp_drop = 0;
    next_frame_switch = 1'b0;
    fb_wr_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("resume_ready", read_rast_pixel_rdy, 1);
    w0 = writes;
    send_pixel(5, 5, 4);
    wait_empty();
    check("resume_write", writes - w0, 1);
    check("resume_display_bank", display_bank, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
